// File: rtl/gpu_stencil_fill_if.sv
// gpu_stencil_fill_if: stencil cache write port bundle
// Signals: stall_i (cache/arbiter busy), stencil_wr_req_o (write strobe),
// stencil_wr_addr_o ({y, cx[9:4]}), stencil_wr_mask_o (per-pixel enable),
// stencil_wr_value_o (replicated fill bit).
// master = fill engine side, slave = stencil cache side.
interface gpu_stencil_fill_if;
  logic        stall_i;
  logic        stencil_wr_req_o;
  logic [14:0] stencil_wr_addr_o;
  logic [15:0] stencil_wr_mask_o;
  logic [15:0] stencil_wr_value_o;
  modport master (
    input  stall_i,
    output stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_mask_o, stencil_wr_value_o
  );
  modport slave (
    output stall_i,
    input  stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_mask_o, stencil_wr_value_o
  );
endinterface

// File: rtl/gpu_stencil_fill.sv
// gpu_stencil_fill: rectangle fill engine issuing masked 16-pixel stencil word writes
// Ports: clk_i, rst_ni (async active-low); start_i/x0_i/y0_i/w_i/h_i/value_i command;
// busy_o fill in progress, done_o one-cycle completion pulse; wr = stencil write port.
// Optional macro GPU_STENCIL_FILL_ABORT_EN adds abort_i (terminate fill early).
// GAP_CYCLES (1..7) idle cycles follow every write so writes are never back to back.
module gpu_stencil_fill #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [9:0]  x0_i,
  input  logic [8:0]  y0_i,
  input  logic [10:0] w_i,
  input  logic [9:0]  h_i,
  input  logic        value_i,
`ifdef GPU_STENCIL_FILL_ABORT_EN
  input  logic        abort_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  gpu_stencil_fill_if.master wr
);
  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_e;
  state_e      state_q, state_d;
  logic [9:0]  x0_q, x0_d, cx_q, cx_d, rows_q, rows_d;
  logic [8:0]  cy_q, cy_d;
  logic [10:0] w_q, w_d, rem_q, rem_d;
  logic        val_q, val_d;
  logic [2:0]  gap_q, gap_d;
  logic [14:0] addr_q;
  logic [15:0] mask_q;
  logic [4:0]  n;
  // pixels covered by the word at cx: up to the word boundary, capped by what remains
  function automatic logic [4:0] span_len(input logic [9:0] cx, input logic [10:0] rem);
    logic [4:0] room;
    room = 5'd16 - {1'b0, cx[3:0]};
    return (rem < {6'd0, room}) ? rem[4:0] : room;
  endfunction
  // 17-bit shift so a full 16-pixel span yields 0xFFFF without overflow
  function automatic logic [15:0] span_mask(input logic [9:0] cx, input logic [10:0] rem);
    logic [16:0] m;
    m = ((17'd1 << span_len(cx, rem)) - 17'd1) << cx[3:0];
    return m[15:0];
  endfunction
  assign n = span_len(cx_q, rem_q);
  assign busy_o = (state_q == WRITE) || (state_q == GAP);
  assign done_o = (state_q == DONE);
  assign wr.stencil_wr_req_o   = (state_q == WRITE) && !wr.stall_i;
  assign wr.stencil_wr_addr_o  = addr_q;
  assign wr.stencil_wr_mask_o  = mask_q;
  assign wr.stencil_wr_value_o = {16{val_q}};
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    w_d     = w_q;
    val_d   = val_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    rem_d   = rem_q;
    rows_d  = rows_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          x0_d    = x0_i;
          w_d     = w_i;
          val_d   = value_i;
          cx_d    = x0_i;
          cy_d    = y0_i;
          rem_d   = w_i;
          rows_d  = h_i;
          state_d = (w_i == '0 || h_i == '0) ? DONE : WRITE;
        end
      end
      WRITE: if (!wr.stall_i) begin
        cx_d    = cx_q + 10'(n);
        rem_d   = rem_q - 11'(n);
        gap_d   = '0;
        state_d = GAP;
        // row finished: step to the next line and reload the horizontal cursor
        if (rem_q == 11'(n)) begin
          cy_d   = cy_q + 9'd1;
          rows_d = rows_q - 10'd1;
          cx_d   = x0_q;
          rem_d  = w_q;
        end
      end
      GAP: begin
        gap_d = gap_q + 3'd1;
        if (gap_q == 3'(GAP_CYCLES - 1)) state_d = (rows_q == '0) ? DONE : WRITE;
      end
    endcase
`ifdef GPU_STENCIL_FILL_ABORT_EN
    // DONE already completes on its own, so only active fill states are cut short
    if (abort_i && busy_o) state_d = DONE;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x0_q    <= '0;
      w_q     <= '0;
      val_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      rem_q   <= '0;
      rows_q  <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      w_q     <= w_d;
      val_q   <= val_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      rem_q   <= rem_d;
      rows_q  <= rows_d;
      gap_q   <= gap_d;
      // word address/mask registered from next-state cursors so they are valid on WRITE entry
      addr_q  <= {cy_d, cx_d[9:4]};
      mask_q  <= span_mask(cx_d, rem_d);
    end
  end
endmodule

// File: tb/tb_gpu_stencil_fill.sv
// tb_gpu_stencil_fill: directed scoreboard bench for gpu_stencil_fill
module tb_gpu_stencil_fill;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  x0_i = '0;
  logic [8:0]  y0_i = '0;
  logic [10:0] w_i = '0;
  logic [9:0]  h_i = '0;
  logic        value_i = 1'b0;
  logic        busy_o, done_o;
`ifdef GPU_STENCIL_FILL_ABORT_EN
  logic        abort_i = 1'b0;
`endif
  gpu_stencil_fill_if wr();
  gpu_stencil_fill dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .x0_i(x0_i), .y0_i(y0_i),
    .w_i(w_i), .h_i(h_i), .value_i(value_i),
`ifdef GPU_STENCIL_FILL_ABORT_EN
    .abort_i(abort_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .wr(wr)
  );
  typedef struct {logic [14:0] a; logic [15:0] m; logic [15:0] v; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  int cmps = 0, errs = 0, cyc = 0, s = 0;
  bit chk = 1'b1, prev_req = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) begin
    if (rst_ni && chk && wr.stencil_wr_req_o) begin
      cmps++;
      assert (prev_req === 1'b0) else begin errs++; $error("FAIL back2back req got 1 want 0 at cycle %0d", cyc - s); end
      cmps++;
      assert (q.size() != 0) else begin errs++; $error("FAIL unexpected_write addr got %0d mask %h want no write", wr.stencil_wr_addr_o, wr.stencil_wr_mask_o); end
      if (q.size() != 0) begin
        e = q.pop_front();
        cmps++;
        assert (wr.stencil_wr_addr_o === e.a) else begin errs++; $error("FAIL wr_addr got %0d want %0d", wr.stencil_wr_addr_o, e.a); end
        cmps++;
        assert (wr.stencil_wr_mask_o === e.m) else begin errs++; $error("FAIL wr_mask got %h want %h (addr %0d)", wr.stencil_wr_mask_o, e.m, e.a); end
        cmps++;
        assert (wr.stencil_wr_value_o === e.v) else begin errs++; $error("FAIL wr_value got %h want %h", wr.stencil_wr_value_o, e.v); end
        if (e.c >= 0) begin
          cmps++;
          assert (cyc - s == e.c) else begin errs++; $error("FAIL wr_cycle got %0d want %0d (addr %0d)", cyc - s, e.c, e.a); end
        end
      end
    end
    prev_req = wr.stencil_wr_req_o;
  end
  task automatic tick(input int k = 1);
    repeat (k) begin @(posedge clk_i); #1; end
  endtask
  task automatic push(input logic [14:0] a, input logic [15:0] m, input logic [15:0] v, input int c);
    q.push_back('{a: a, m: m, v: v, c: c});
  endtask
  task automatic start(input logic [9:0] x, input logic [8:0] y, input logic [10:0] w, input logic [9:0] h, input logic v);
    x0_i = x; y0_i = y; w_i = w; h_i = h; value_i = v;
    start_i = 1'b1;
    s = cyc;
    tick();
    start_i = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int exp, input int limit);
    while (done_o !== 1'b1 && cyc - s < limit) tick();
    cmps++;
    assert (done_o === 1'b1 && cyc - s == exp) else begin errs++; $error("FAIL %s done_cycle got %0d (done=%b) want %0d", tag, cyc - s, done_o, exp); end
    cmps++;
    assert (busy_o === 1'b0) else begin errs++; $error("FAIL %s busy_at_done got %b want 0", tag, busy_o); end
    cmps++;
    assert (q.size() == 0) else begin errs++; $error("FAIL %s writes_missing got %0d pending want 0", tag, q.size()); end
    q.delete();
    tick();
    cmps++;
    assert (done_o === 1'b0) else begin errs++; $error("FAIL %s done_pulse_width got %b want 0", tag, done_o); end
  endtask
  initial begin
    wr.stall_i = 1'b0;
    tick(2);
    cmps++;
    assert ({busy_o, done_o, wr.stencil_wr_req_o, wr.stencil_wr_addr_o, wr.stencil_wr_mask_o, wr.stencil_wr_value_o} === '0)
      else begin errs++; $error("FAIL reset_outputs got nonzero want all 0"); end
    rst_ni = 1'b1;
    tick();
    // split row
    push(15'd192, 16'hFF00, 16'hFFFF, 1);
    push(15'd193, 16'h0FFF, 16'hFFFF, 3);
    start(10'd8, 9'd3, 11'd20, 10'd1, 1'b1);
    cmps++;
    assert (busy_o === 1'b1) else begin errs++; $error("FAIL busy_cycle1 got %b want 1", busy_o); end
    wait_done("split", 5, 50);
    // wrap in both axes, with an ignored start while busy
    push(15'd32767, 16'hF000, 16'h0000, 1);
    push(15'd32704, 16'h000F, 16'h0000, 3);
    push(15'd63,    16'hF000, 16'h0000, 5);
    push(15'd0,     16'h000F, 16'h0000, 7);
    start(10'd1020, 9'd511, 11'd8, 10'd2, 1'b0);
    tick();
    x0_i = 10'd0; y0_i = 9'd0; w_i = 11'd16; h_i = 10'd1; value_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done("wrap", 9, 50);
    // stall for 3 cycles at the second write
    push(15'd192, 16'hFF00, 16'hFFFF, 1);
    push(15'd193, 16'h0FFF, 16'hFFFF, 6);
    start(10'd8, 9'd3, 11'd20, 10'd1, 1'b1);
    tick(2);
    wr.stall_i = 1'b1;
    tick();
    cmps++;
    assert (busy_o === 1'b1) else begin errs++; $error("FAIL busy_in_stall got %b want 1", busy_o); end
    tick(2);
    wr.stall_i = 1'b0;
    wait_done("stall", 8, 50);
    // zero-size rectangles
    start(10'd100, 9'd7, 11'd0, 10'd3, 1'b1);
    wait_done("zero_w", 1, 20);
    start(10'd0, 9'd0, 11'd16, 10'd0, 1'b1);
    wait_done("zero_h", 1, 20);
    // unaligned full width
    push(15'd128, 16'hFFE0, 16'hFFFF, 1);
    for (int k = 1; k < 64; k++) push(15'(128 + k), 16'hFFFF, 16'hFFFF, 1 + 2 * k);
    push(15'd128, 16'h001F, 16'hFFFF, 129);
    start(10'd5, 9'd2, 11'd1024, 10'd1, 1'b1);
    wait_done("unaligned", 131, 400);
    // asynchronous reset mid-fill
    chk = 1'b0;
    start(10'd0, 9'd0, 11'd1024, 10'd4, 1'b1);
    tick(2);
    #2 rst_ni = 1'b0;
    #1;
    cmps++;
    assert ({busy_o, done_o, wr.stencil_wr_req_o, wr.stencil_wr_addr_o, wr.stencil_wr_mask_o, wr.stencil_wr_value_o} === '0)
      else begin errs++; $error("FAIL async_reset got busy=%b done=%b req=%b addr=%0d mask=%h val=%h want all 0", busy_o, done_o, wr.stencil_wr_req_o, wr.stencil_wr_addr_o, wr.stencil_wr_mask_o, wr.stencil_wr_value_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    chk = 1'b1;
    push(15'd576, 16'hFF00, 16'hFFFF, 1);
    push(15'd577, 16'h0FFF, 16'hFFFF, 3);
    start(10'd8, 9'd9, 11'd20, 10'd1, 1'b1);
    wait_done("after_reset", 5, 50);
`ifdef GPU_STENCIL_FILL_ABORT_EN
    for (int k = 0; k < 4; k++) push(15'(k), 16'hFFFF, 16'hFFFF, 1 + 2 * k);
    start(10'd0, 9'd0, 11'd160, 10'd1, 1'b1);
    tick(6);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    wait_done("abort", 8, 50);
`endif
    // full-plane clear
    for (int k = 0; k < 32768; k++) push(15'(k), 16'hFFFF, 16'h0000, 1 + 2 * k);
    start(10'd0, 9'd0, 11'd1024, 10'd512, 1'b0);
    wait_done("full_plane", 65537, 70000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
